// File: rtl/decode_pkg.sv
// Shared RV32I decode constants: ALU op codes, major opcodes, funct7 values
// and operand-select encodings used by the decode stage.
package decode_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_t;
  typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} b_sel_t;

  // alt selects SUB (f3=000) or SRA (f3=101); ignored for other funct3 values.
  function automatic logic [3:0] f3_to_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_to_alu = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f3_to_alu = ALU_SLL;
      3'b010:  f3_to_alu = ALU_SLT;
      3'b011:  f3_to_alu = ALU_SLTU;
      3'b100:  f3_to_alu = ALU_XOR;
      3'b101:  f3_to_alu = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f3_to_alu = ALU_OR;
      default: f3_to_alu = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction; format chosen from the opcode,
// all immediates sign-extended from instr[31].
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {instr[31:12], 12'd0};
      OPC_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/id_decode_reg.sv
// Instruction-decode stage: decodes RV32I into ALU op and operands, then
// registers the result with valid/stall/flush control for the execute stage.
module id_decode_reg
  import decode_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic        i_valid,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output logic        o_valid,
  output logic [3:0]  o_alu_op,
  output logic [31:0] o_operand_a,
  output logic [31:0] o_operand_b,
  output logic [31:0] o_rs2_data,
  output logic [4:0]  o_rd_addr,
  output logic        o_rd_wren,
  output logic [31:0] o_pc,
  output logic        o_illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm;

  logic [3:0]  dec_alu_op;
  a_sel_t      dec_a_sel;
  b_sel_t      dec_b_sel;
  logic        dec_shamt;
  logic        dec_wren;
  logic        dec_illegal;
  logic [31:0] opnd_a;
  logic [31:0] opnd_b;

  assign opcode     = i_instr[6:0];
  assign rd         = i_instr[11:7];
  assign funct3     = i_instr[14:12];
  assign funct7     = i_instr[31:25];
  assign o_rs1_addr = i_instr[19:15];
  assign o_rs2_addr = i_instr[24:20];

  imm_gen u_imm_gen (
    .instr (i_instr),
    .imm   (imm)
  );

  always_comb begin
    dec_alu_op  = ALU_ADD;
    dec_a_sel   = A_RS1;
    dec_b_sel   = B_RS2;
    dec_shamt   = 1'b0;
    dec_wren    = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_wren   = 1'b1;
        dec_alu_op = f3_to_alu(funct3, funct7 == F7_ALT);
        if (funct7 != F7_BASE && funct7 != F7_ALT) dec_illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_wren  = 1'b1;
        dec_b_sel = B_IMM;
        // funct7 only exists for shifts; elsewhere those bits are immediate.
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_shamt  = 1'b1;
          dec_alu_op = f3_to_alu(funct3, funct7 == F7_ALT);
          if (funct7 != F7_BASE && funct7 != F7_ALT) dec_illegal = 1'b1;
        end else begin
          dec_alu_op = f3_to_alu(funct3, 1'b0);
        end
      end
      OPC_LUI: begin
        dec_wren  = 1'b1;
        dec_a_sel = A_ZERO;
        dec_b_sel = B_IMM;
      end
      OPC_AUIPC: begin
        dec_wren  = 1'b1;
        dec_a_sel = A_PC;
        dec_b_sel = B_IMM;
      end
      OPC_LOAD: begin
        dec_wren  = 1'b1;
        dec_b_sel = B_IMM;
      end
      OPC_STORE: begin
        dec_b_sel = B_IMM;
      end
      OPC_BRANCH: begin
        dec_a_sel = A_PC;
        dec_b_sel = B_IMM;
      end
      OPC_JAL, OPC_JALR: begin
        dec_wren  = 1'b1;
        dec_a_sel = A_PC;
        dec_b_sel = B_FOUR;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_alu_op = ALU_ADD;
      dec_wren   = 1'b0;
    end
    if (rd == 5'd0) dec_wren = 1'b0;
  end

  always_comb begin
    case (dec_a_sel)
      A_PC:    opnd_a = i_pc;
      A_ZERO:  opnd_a = '0;
      default: opnd_a = i_rs1_data;
    endcase
    case (dec_b_sel)
      B_IMM:   opnd_b = dec_shamt ? {27'd0, i_instr[24:20]} : imm;
      B_FOUR:  opnd_b = 32'd4;
      default: opnd_b = i_rs2_data;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid     <= 1'b0;
      o_alu_op    <= ALU_ADD;
      o_operand_a <= '0;
      o_operand_b <= '0;
      o_rs2_data  <= '0;
      o_rd_addr   <= '0;
      o_rd_wren   <= 1'b0;
      o_pc        <= '0;
      o_illegal   <= 1'b0;
    end else if (i_flush) begin
      o_valid   <= 1'b0;
      o_rd_wren <= 1'b0;
      o_illegal <= 1'b0;
    end else if (!i_stall) begin
      o_valid     <= i_valid;
      o_alu_op    <= dec_alu_op;
      o_operand_a <= opnd_a;
      o_operand_b <= opnd_b;
      o_rs2_data  <= i_rs2_data;
      o_rd_addr   <= rd;
      o_rd_wren   <= i_valid & dec_wren;
      o_pc        <= i_pc;
      o_illegal   <= i_valid & dec_illegal;
    end
  end

endmodule
